// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I subset with one shared memory port.
// Build macro ILLEGAL_TRAP_EN: illegal opcodes halt and set illegal_instr instead of retiring as NOPs.
module multicycle_control #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instret,
  output logic             bus_error,
  output logic             illegal_instr
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_IARITH, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_LUI, C_ILLEGAL
  } class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IARITH = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  state_t           state_reg, state_next;
  class_t           class_reg, class_dec;
  logic [CNT_W-1:0] instret_reg;
  logic             bus_error_reg;
  logic             retire;
  logic             timeout_hit;
  logic             mem_wait;

  assign mem_wait = (state_reg == S_FETCH) || (state_reg == S_MEM);

  always_comb begin
    class_dec = C_ILLEGAL;
    case (opcode)
      OP_R:      class_dec = C_R;
      OP_IARITH: class_dec = C_IARITH;
      OP_LOAD:   class_dec = C_LOAD;
      OP_STORE:  class_dec = C_STORE;
      OP_BRANCH: class_dec = C_BRANCH;
      OP_JAL:    class_dec = C_JAL;
      OP_LUI:    class_dec = C_LUI;
      default:   class_dec = C_ILLEGAL;
    endcase
  end

  // Wait counter exists only when a timeout limit is configured; it tracks
  // consecutive unanswered request cycles and a same-cycle mem_ready wins.
  generate
    if (MEM_TIMEOUT > 0) begin : g_timeout
      localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
      localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MEM_TIMEOUT - 1);
      logic [WAIT_W-1:0] wait_cnt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wait_cnt_reg <= '0;
        end else if (mem_wait && !mem_ready && !timeout_hit) begin
          wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end else begin
          wait_cnt_reg <= '0;
        end
      end

      assign timeout_hit = mem_wait && !mem_ready && (wait_cnt_reg == LIMIT);
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_FETCH;
      class_reg     <= C_R;
      instret_reg   <= '0;
      bus_error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DECODE) begin
        class_reg <= class_dec;
      end
      if (retire) begin
        instret_reg <= instret_reg + 1'b1;
      end
      if (timeout_hit) begin
        bus_error_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    case (state_reg)
      S_FETCH: begin
        if (mem_ready) begin
          state_next = S_DECODE;
        end else if (timeout_hit) begin
          state_next = S_HALT;
        end
      end
      S_DECODE: begin
        if (class_dec == C_ILLEGAL) begin
`ifdef ILLEGAL_TRAP_EN
          state_next = S_HALT;
`else
          state_next = S_FETCH;
          retire     = 1'b1;
`endif
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        case (class_reg)
          C_LOAD, C_STORE: state_next = S_MEM;
          C_BRANCH: begin
            state_next = S_FETCH;
            retire     = 1'b1;
          end
          C_R, C_IARITH, C_JAL, C_LUI: state_next = S_WB;
          default: state_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (class_reg == C_STORE) begin
            state_next = S_FETCH;
            retire     = 1'b1;
          end else begin
            state_next = S_WB;
          end
        end else if (timeout_hit) begin
          state_next = S_HALT;
        end
      end
      S_WB: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

  // Everything here is gated by rst_n so a reset mid-access drops the bus at once.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    alu_src_b = 1'b0;
    alu_op    = 2'b00;
    reg_write = 1'b0;
    wb_sel    = 2'b00;
    if (rst_n) begin
      mem_req = mem_wait;
      case (state_reg)
        S_FETCH: begin
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_EXEC: begin
          case (class_reg)
            C_R: alu_op = 2'b10;
            C_IARITH: begin
              alu_op    = 2'b10;
              alu_src_b = 1'b1;
            end
            C_LOAD, C_STORE: alu_src_b = 1'b1;
            C_BRANCH: begin
              alu_op   = 2'b01;
              pc_write = zero;
              pc_src   = 2'b01;
            end
            C_JAL: begin
              pc_write = 1'b1;
              pc_src   = 2'b10;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          iord   = 1'b1;
          mem_we = (class_reg == C_STORE);
        end
        S_WB: begin
          reg_write = 1'b1;
          case (class_reg)
            C_LOAD:  wb_sel = 2'b01;
            C_JAL:   wb_sel = 2'b10;
            C_LUI:   wb_sel = 2'b11;
            default: wb_sel = 2'b00;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign state_o   = state_reg;
  assign instret   = instret_reg;
  assign bus_error = bus_error_reg;

`ifdef ILLEGAL_TRAP_EN
  logic illegal_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_reg <= 1'b0;
    end else if (state_reg == S_DECODE && class_dec == C_ILLEGAL) begin
      illegal_reg <= 1'b1;
    end
  end
  assign illegal_instr = illegal_reg;
`else
  assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: expected bus, PC, writeback,
// state and retire events are queued per instruction and matched by a negedge monitor.
module tb_multicycle_control;
  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 4;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [6:0] OP_J = 7'b1101111;
  localparam logic [6:0] OP_U = 7'b0110111;

  localparam int K_RET   = 0;
  localparam int K_STATE = 1;
  localparam int K_MEM   = 2;
  localparam int K_PCW   = 3;
  localparam int K_RW    = 4;

  typedef struct {
    int kind;
    int a;
    int b;
    int c;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [6:0]       opcode = 7'd0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0]       pc_src, alu_op, wb_sel;
  logic             alu_src_b, reg_write, bus_error, illegal_instr;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] instret;

  int  n_tests = 0;
  int  n_fail = 0;
  int  n_retired = 0;
  int  n_instr = 0;
  bit  mon_en = 1'b0;
  ev_t exp_q[$];

  multicycle_control #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .wb_sel(wb_sel), .state_o(state_o), .instret(instret),
    .bus_error(bus_error), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void push(input int k, input int a, input int b, input int c);
    ev_t e;
    e.kind = k;
    e.a    = a;
    e.b    = b;
    e.c    = c;
    exp_q.push_back(e);
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return op == OP_R || op == OP_I || op == OP_L || op == OP_S ||
           op == OP_B || op == OP_J || op == OP_U;
  endfunction

  // Reference: per-class latency table and the externally visible events of one instruction.
  task automatic run_instr(input logic [6:0] op, input logic z, input int w1, input int w2);
    int lat;
    int mem_at;
    bit ls;
    ls = (op == OP_L) || (op == OP_S);
    if (!is_legal(op))  lat = 2;
    else if (op == OP_B) lat = 3;
    else if (op == OP_L) lat = 5;
    else                 lat = 4;
    lat    = lat + w1 + (ls ? w2 : 0);
    mem_at = w1 + 3 + w2;

    push(K_MEM, 0, 0, 0);
    push(K_PCW, 0, 0, 0);
    push(K_STATE, 1, 0, 0);
    if (is_legal(op)) begin
      case (op)
        OP_R:       push(K_STATE, 2, 1, 4);
        OP_I:       push(K_STATE, 2, 1, 5);
        OP_L, OP_S: push(K_STATE, 2, 1, 1);
        OP_B:       push(K_STATE, 2, 1, 2);
        default:    push(K_STATE, 2, 0, 0);
      endcase
      if (op == OP_B && z) push(K_PCW, 1, 0, 0);
      if (op == OP_J)      push(K_PCW, 2, 0, 0);
      if (ls) begin
        push(K_STATE, 3, 0, 0);
        push(K_MEM, (op == OP_S) ? 1 : 0, 1, 0);
      end
      if (op != OP_B && op != OP_S) begin
        push(K_STATE, 4, 0, 0);
        case (op)
          OP_L:    push(K_RW, 1, 0, 0);
          OP_J:    push(K_RW, 2, 0, 0);
          OP_U:    push(K_RW, 3, 0, 0);
          default: push(K_RW, 0, 0, 0);
        endcase
      end
    end
    n_retired++;
    push(K_RET, n_retired % (1 << CNT_W), lat, 0);
    push(K_STATE, 0, 0, 0);

    n_instr++;
    $display("[TB] instr %0d op=%b zero=%0d fetch_wait=%0d mem_wait=%0d latency=%0d",
             n_instr, op, z, w1, ls ? w2 : 0, lat);
    zero = z;
    for (int c = 0; c < lat; c++) begin
      opcode = (c <= w1) ? 7'($urandom) : op;
      if (c < w1)                               mem_ready = 1'b0;
      else if (c == w1)                         mem_ready = 1'b1;
      else if (ls && c >= w1 + 3 && c < mem_at) mem_ready = 1'b0;
      else if (ls && c == mem_at)               mem_ready = 1'b1;
      else                                      mem_ready = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    mon_en    = 1'b0;
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    n_retired = 0;
    exp_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_mem_req_forced_low", mem_req, 0);
    chk("reset_state", state_o, 0);
    rst_n = 1'b1;
  endtask

  task automatic expect_pop(input int kind, input string what, output ev_t e, output bit ok);
    ok     = 1'b0;
    e.kind = 0;
    e.a    = 0;
    e.b    = 0;
    e.c    = 0;
    if (exp_q.size() == 0 || exp_q[0].kind != kind) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got an unexpected DUT event, expected event kind %0d (pending %0d)",
               what, (exp_q.size() == 0) ? -1 : exp_q[0].kind, exp_q.size());
    end else begin
      e  = exp_q.pop_front();
      ok = 1'b1;
    end
  endtask

  int         cyc;
  int         last_ret;
  logic [CNT_W-1:0] prev_instret;
  logic [2:0] prev_state;
  bit         armed = 1'b0;

  always @(negedge clk) begin
    ev_t e;
    bit  ok;
    if (!mon_en) begin
      armed = 1'b0;
    end else begin
      if (!armed) begin
        armed        = 1'b1;
        cyc          = 0;
        last_ret     = 1;
        prev_instret = instret;
        prev_state   = state_o;
      end
      cyc++;
      if (instret != prev_instret) begin
        expect_pop(K_RET, "retire", e, ok);
        if (ok) begin
          chk("instret", instret, e.a);
          chk("latency", cyc - last_ret, e.b);
        end
        last_ret = cyc;
      end
      prev_instret = instret;
      if (state_o != prev_state) begin
        expect_pop(K_STATE, "state_change", e, ok);
        if (ok) begin
          chk("state_seq", state_o, e.a);
          if (e.b != 0) chk("exec_alu_op_src_b", {alu_op, alu_src_b}, e.c);
        end
      end
      prev_state = state_o;
      if (mem_req && mem_ready) begin
        expect_pop(K_MEM, "mem_handshake", e, ok);
        if (ok) begin
          chk("mem_we", mem_we, e.a);
          chk("iord", iord, e.b);
        end
      end
      chk("ir_write_only_on_fetch", ir_write, (mem_req && mem_ready && !iord) ? 1 : 0);
      if (pc_write) begin
        expect_pop(K_PCW, "pc_write", e, ok);
        if (ok) chk("pc_src", pc_src, e.a);
      end
      if (reg_write) begin
        expect_pop(K_RW, "reg_write", e, ok);
        if (ok) chk("wb_sel", wb_sel, e.a);
      end
    end
  end

  initial begin
    logic [6:0] op;
    int         pick;

    // Reset values while rst_n is held low
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_state", state_o, 0);
    chk("reset_instret", instret, 0);
    chk("reset_bus_error", bus_error, 0);
    chk("reset_illegal", illegal_instr, 0);
    chk("reset_mem_req_forced_low", mem_req, 0);

    // Directed then random instruction stream through the scoreboard
    do_reset();
    mon_en = 1'b1;
    run_instr(OP_R, 1'b0, 0, 0);
    run_instr(OP_L, 1'b0, 0, 2);
    run_instr(OP_B, 1'b1, 0, 0);
    run_instr(OP_B, 1'b0, 0, 0);
    run_instr(OP_U, 1'b0, 0, 0);
    run_instr(OP_J, 1'b0, 1, 0);
    run_instr(OP_S, 1'b0, 0, 3);
    run_instr(OP_I, 1'b0, 3, 0);
`ifndef ILLEGAL_TRAP_EN
    run_instr(7'b1111111, 1'b0, 0, 0);
`endif
    for (int n = 0; n < 80; n++) begin
`ifdef ILLEGAL_TRAP_EN
      pick = int'($urandom_range(0, 6));
`else
      pick = int'($urandom_range(0, 7));
`endif
      case (pick)
        0: op = OP_R;
        1: op = OP_I;
        2: op = OP_L;
        3: op = OP_S;
        4: op = OP_B;
        5: op = OP_J;
        6: op = OP_U;
        default: begin
          op = 7'($urandom);
          while (is_legal(op)) op = 7'($urandom);
        end
      endcase
      run_instr(op, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    mem_ready = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    mon_en = 1'b0;
    chk("scoreboard_drained", exp_q.size(), 0);

    // Fetch timeout: four unanswered cycles halt with bus_error
    do_reset();
    mem_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("timeout_limit_cycle_state", state_o, 0);
    chk("timeout_limit_cycle_mem_req", mem_req, 1);
    chk("timeout_limit_cycle_bus_error", bus_error, 0);
    @(posedge clk); #1;
    chk("timeout_state_halt", state_o, 5);
    chk("timeout_bus_error", bus_error, 1);
    chk("timeout_mem_req_low", mem_req, 0);
    mem_ready = 1'b1;
    opcode    = OP_R;
    repeat (6) begin
      @(posedge clk); #1;
    end
    chk("halt_sticky_state", state_o, 5);
    chk("halt_instret_frozen", instret, 0);
    chk("halt_bus_error_sticky", bus_error, 1);

    // Same run with mem_ready on the 4th cycle: ready wins
    do_reset();
    chk("bus_error_cleared_by_reset", bus_error, 0);
    mem_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    opcode    = OP_R;
    @(posedge clk); #1;
    chk("ready_at_limit_state_decode", state_o, 1);
    chk("ready_at_limit_no_error", bus_error, 0);

    // Illegal opcode
    do_reset();
    mem_ready = 1'b1;
    opcode    = 7'b1111111;
    @(posedge clk); #1;
    chk("illegal_decode_state", state_o, 1);
    mem_ready = 1'b0;
    @(posedge clk); #1;
`ifdef ILLEGAL_TRAP_EN
    chk("illegal_trap_state", state_o, 5);
    chk("illegal_trap_flag", illegal_instr, 1);
    chk("illegal_trap_instret", instret, 0);
    mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("illegal_trap_halt_sticky", state_o, 5);
    chk("illegal_trap_mem_req_low", mem_req, 0);
`else
    chk("illegal_nop_state", state_o, 0);
    chk("illegal_nop_instret", instret, 1);
    chk("illegal_nop_flag_tied_low", illegal_instr, 0);
`endif

    // Reset in the middle of a store access
    do_reset();
    mem_ready = 1'b1;
    opcode    = OP_R;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("pre_store_instret", instret, 1);
    chk("pre_store_state", state_o, 0);
    opcode    = OP_S;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("store_mem_req", mem_req, 1);
    chk("store_mem_we", mem_we, 1);
    chk("store_iord", iord, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_mem_req", mem_req, 0);
    chk("async_reset_mem_we", mem_we, 0);
    chk("async_reset_instret", instret, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post_reset_state", state_o, 0);
    chk("post_reset_instret", instret, 0);
    chk("post_reset_bus_error", bus_error, 0);
    chk("post_reset_no_write", mem_we, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle sequencer for the RV32I datapath subset (R, I-arith, load, store, branch, JAL, LUI).
- Steps one instruction at a time through FETCH/DECODE/EXEC/MEM/WB and drives all datapath enables and muxes.
- Shares one unified memory port between instruction fetch and data access through a req/ready handshake.
- Counts retired instructions and flags memory-bus timeouts.

Parameters:
CNT_W, 32, width of retired-instruction counter instret.
MEM_TIMEOUT, 0, max cycles mem_req may wait for mem_ready before bus_error; 0 disables the timeout.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
opcode  input  7  instr[6:0] from the instruction register; valid from DECODE onward
zero  input  1  ALU zero flag, sampled in EXEC for branches
mem_ready  input  1  memory completes the current access this cycle
mem_req  output  1  memory access request
mem_we  output  1  write strobe, valid with mem_req
iord  output  1  0 = address from PC, 1 = address from ALUOut
ir_write  output  1  load instruction register
pc_write  output  1  load PC
pc_src  output  2  00 = PC+4, 01 = branch target, 10 = JAL target
alu_src_b  output  1  0 = rs2, 1 = immediate
alu_op  output  2  00 = add, 01 = sub/compare, 10 = funct-decoded
reg_write  output  1  register file write enable
wb_sel  output  2  00 = ALUOut, 01 = memory data, 10 = PC+4 (link), 11 = immediate (LUI)
state_o  output  3  current state encoding
instret  output  CNT_W  retired-instruction count
bus_error  output  1  sticky memory-timeout flag
illegal_instr  output  1  sticky illegal-opcode flag (feature-dependent)

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=FETCH, instret=0, bus_error=0, illegal_instr=0, wait counter=0.
  - All combinational outputs are forced to 0 while rst_n=0.
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Outputs are Moore from state plus the latched opcode class. Branch pc_write alone also depends on zero.
- FETCH:
  - Drive mem_req=1, iord=0, mem_we=0; hold until mem_ready.
  - Cycle mem_ready=1: ir_write=1, pc_write=1, pc_src=00; next state DECODE.
- DECODE:
  - Latch opcode class; no enables asserted.
  - Recognised opcodes (0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 0110111) go to EXEC.
  - Any other opcode is illegal; handling per optional feature.
- EXEC, by class:
  - R: alu_op=10, alu_src_b=0; next WB.
  - I-arith: alu_op=10, alu_src_b=1; next WB.
  - Load/store: alu_op=00, alu_src_b=1 (address calc); next MEM.
  - Branch: alu_op=01, alu_src_b=0; pc_write=zero, pc_src=01; next FETCH; retires.
  - JAL: pc_write=1, pc_src=10; next WB.
  - LUI: no enables; next WB.
- MEM:
  - Drive mem_req=1, iord=1, mem_we=1 for store / 0 for load; hold until mem_ready.
  - On mem_ready: store goes to FETCH and retires; load goes to WB.
- WB:
  - reg_write=1 for one cycle; next FETCH; retires.
  - wb_sel: 00 for R and I-arith, 01 for load, 10 for JAL, 11 for LUI.
- Retire: instret increments by 1 on the retiring transition and wraps modulo 2^CNT_W.
- Latency:
  - 4 cycles: R, I-arith, LUI, JAL.
  - 3 cycles: branch.
  - 4 cycles: store.
  - 5 cycles: load.
  - Each count assumes mem_ready on the first request cycle; every wait cycle adds 1.
- Handshake:
  - mem_req, iord, mem_we and the address source stay stable until mem_ready.
  - mem_ready sampled outside FETCH/MEM is ignored.
- Timeout (MEM_TIMEOUT>0):
  - The wait counter counts consecutive cycles with mem_req=1 and mem_ready=0, and clears on mem_ready.
  - When the count reaches MEM_TIMEOUT: bus_error=1, next state HALT.
  - mem_ready arriving in the same cycle as the limit wins: no error.
- HALT: all enables 0; instret frozen; exits only via reset.
- Reset mid-access: mem_req drops immediately (asynchronously); no partial write is signalled after reset.

Optional Feature:
Macro ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE sets illegal_instr=1 (sticky), goes to HALT, and does not retire.
- Undefined: an illegal opcode is treated as NOP: DECODE goes to FETCH, instret increments, and illegal_instr is tied to 0.

Test Plan:
- R-type 0110011, mem_ready always 1 -> states 0,1,2,4,0; reg_write=1 only in WB, wb_sel=00; instret 0->1 after 4 cycles.
- Load 0000011, mem_ready delayed 2 cycles in MEM -> mem_req/iord=1 held 3 cycles; WB wb_sel=01; total 7 cycles; instret+1.
- Branch 1100011, first with zero=1 then zero=0 -> pc_write=1 with pc_src=01 in EXEC for the first, pc_write=0 for the second; each takes 3 cycles.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> after 4 waiting cycles bus_error=1, state_o=5, mem_req=0; the run is then repeated with mem_ready arriving on the 4th cycle -> no error.
- Opcode 1111111 -> with ILLEGAL_TRAP_EN: illegal_instr=1, state_o=5, instret unchanged; without: back to FETCH, instret+1.
- rst_n asserted mid-MEM store -> mem_req/mem_we drop the same cycle; after release, state_o=0, instret=0, bus_error=0.
